// File: rtl/sar_afe_model_if.sv
// Stimulus stream into the SAR analog front-end model.
// Carries ideal input codes with a valid/ready handshake.
interface sar_afe_model_if #(
    parameter int RESOLUTION = 8
);
    logic                  vin_valid_i;
    logic [RESOLUTION-1:0] vin_i;
    logic                  vin_ready_o;

    modport master (
        output vin_valid_i,
        output vin_i,
        input  vin_ready_o
    );

    modport slave (
        input  vin_valid_i,
        input  vin_i,
        output vin_ready_o
    );
endinterface

// File: rtl/sar_afe_model.sv
// Behavioural SAR front end: sampled input, cap DAC and comparator, plus scoreboard.
// Optional comparator offset port enabled by SAR_AFE_OFFSET_EN.
module sar_afe_model #(
    parameter int RESOLUTION = 8,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    sar_afe_model_if.slave               vin_if,
    input  logic                         sample_i,
    input  logic [RESOLUTION-1:0]        dac_p_i,
    input  logic [RESOLUTION-1:0]        dac_n_i,
    output logic                         comp_p_o,
    output logic                         comp_n_o,
    input  logic                         rdy_i,
    input  logic [RESOLUTION-1:0]        result_i,
`ifdef SAR_AFE_OFFSET_EN
    input  logic signed [RESOLUTION-1:0] offset_i,
`endif
    output logic [RESOLUTION-1:0]        expected_o,
    output logic [CNT_WIDTH-1:0]         conv_cnt_o,
    output logic [CNT_WIDTH-1:0]         err_cnt_o,
    output logic                         mismatch_o,
    output logic                         underflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int VW = RESOLUTION + 3;
    localparam logic [VW-1:0] HALF = VW'(1) << RESOLUTION;

    typedef enum logic {IDLE, CONV} state_t;

    state_t                       state;
    logic [RESOLUTION-1:0]        mem [DEPTH];
    logic [AW:0]                  wr_ptr, rd_ptr;
    logic [RESOLUTION-1:0]        u_q;
    logic                         sample_q, rdy_q;
    logic                         full, empty, push, pop;
    logic                         sample_rise, rdy_rise, check;
    logic signed [RESOLUTION+1:0] off_ext, sum;
    logic [VW-1:0]                v, diff;
    logic                         gt;
    logic [RESOLUTION-1:0]        exp_code;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign vin_if.vin_ready_o = ~full;
    assign push = vin_if.vin_valid_i & ~full;

    assign sample_rise = sample_i & ~sample_q;
    assign rdy_rise    = rdy_i & ~rdy_q;
    assign pop         = sample_rise & ~empty;
    assign check       = (state == CONV) & rdy_rise;

`ifdef SAR_AFE_OFFSET_EN
    assign off_ext = {{2{offset_i[RESOLUTION-1]}}, offset_i};
`else
    assign off_ext = '0;
`endif

    // Odd threshold 2*(u+off)+1-2^R keeps the comparator free of ties.
    assign sum  = $signed({2'b00, u_q}) + off_ext;
    assign v    = {sum[RESOLUTION+1], sum, 1'b1} - HALF;
    assign diff = {3'b000, dac_p_i} - {3'b000, dac_n_i};
    assign gt   = $signed(v) > $signed(diff);

    assign comp_p_o = (state == CONV) & gt;
    assign comp_n_o = (state == CONV) & ~gt;

    always_comb begin
        exp_code = sum[RESOLUTION-1:0];
        if (sum[RESOLUTION+1])
            exp_code = '0;
        else if (sum[RESOLUTION])
            exp_code = '1;
    end

    assign expected_o = exp_code;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            u_q         <= '0;
            sample_q    <= 1'b0;
            rdy_q       <= 1'b0;
            conv_cnt_o  <= '0;
            err_cnt_o   <= '0;
            mismatch_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            sample_q <= sample_i;
            rdy_q    <= rdy_i;
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= vin_if.vin_i;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            // Result check uses the code held before any same-cycle reload.
            if (check) begin
                if (conv_cnt_o != '1)
                    conv_cnt_o <= conv_cnt_o + 1'b1;
                if (result_i != exp_code) begin
                    mismatch_o <= 1'b1;
                    if (err_cnt_o != '1)
                        err_cnt_o <= err_cnt_o + 1'b1;
                end
            end
            if (pop) begin
                u_q    <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (sample_rise && empty)
                underflow_o <= 1'b1;
            if (sample_rise)
                state <= pop ? CONV : IDLE;
            else if (check)
                state <= IDLE;
        end
    end
endmodule

// File: tb/tb_sar_afe_model.sv
// Self-checking bench for sar_afe_model: vector table, corner sequences, random run.
module tb_sar_afe_model;
    localparam int R  = 8;
    localparam int D  = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sar_afe_model_if #(.RESOLUTION(R)) vif();

    logic                sample = 1'b0, rdy = 1'b0;
    logic [R-1:0]        dac_p = '0, dac_n = '0, result = '0;
    logic                comp_p, comp_n, mismatch, underflow;
    logic [R-1:0]        expected;
    logic [CW-1:0]       conv_cnt, err_cnt;
    logic signed [R-1:0] offset = '0;

    sar_afe_model #(.RESOLUTION(R), .DEPTH(D), .CNT_WIDTH(CW)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .vin_if(vif),
        .sample_i(sample),
        .dac_p_i(dac_p),
        .dac_n_i(dac_n),
        .comp_p_o(comp_p),
        .comp_n_o(comp_n),
        .rdy_i(rdy),
        .result_i(result),
`ifdef SAR_AFE_OFFSET_EN
        .offset_i(offset),
`endif
        .expected_o(expected),
        .conv_cnt_o(conv_cnt),
        .err_cnt_o(err_cnt),
        .mismatch_o(mismatch),
        .underflow_o(underflow)
    );

    // Reference model: queue of codes and the ideal scoreboard state
    int mq[$];
    int mu, m_conv, m_err;
    bit m_mis, m_unf, mst;
    int resq[$];
    int checks = 0;
    int errors = 0;

    typedef struct {
        int code;
        bit bad;
        int exp_res;
        int exp_comps;
    } vec_t;

    function automatic int clampv(int x);
        if (x < 0) return 0;
        if (x > (1 << R) - 1) return (1 << R) - 1;
        return x;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_rise();
        if (mq.size() > 0) begin
            mu  = mq.pop_front();
            mst = 1'b1;
        end else begin
            m_unf = 1'b1;
            mst   = 1'b0;
        end
    endtask

    task automatic model_clear();
        mq.delete();
        mu = 0; m_conv = 0; m_err = 0;
        m_mis = 1'b0; m_unf = 1'b0; mst = 1'b0;
    endtask

    task automatic check_reset_state();
        chk("rst_ready", int'(vif.vin_ready_o), 1);
        chk("rst_expected", int'(expected), 0);
        chk("rst_conv_cnt", int'(conv_cnt), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_mismatch", int'(mismatch), 0);
        chk("rst_underflow", int'(underflow), 0);
        chk("rst_comp_p", int'(comp_p), 0);
        chk("rst_comp_n", int'(comp_n), 0);
    endtask

    task automatic push(int c);
        int er;
        er = (mq.size() < D) ? 1 : 0;
        vif.vin_valid_i = 1'b1;
        vif.vin_i = R'(c);
        #1 chk("vin_ready", int'(vif.vin_ready_o), er);
        @(negedge clk);
        vif.vin_valid_i = 1'b0;
        if (er == 1) mq.push_back(c);
    endtask

    // Ideal SAR controller: n conversions, back-to-back via rdy/sample overlap
    task automatic conv_seq(int n, bit bad_last, output int comps);
        int t, trial, res, expc;
        comps = 0;
        sample = 1'b1;
        @(negedge clk);
        model_rise();
        sample = 1'b0;
        for (int k = 0; k < n; k++) begin
            chk("expected_o", int'(expected), clampv(mu + int'(offset)));
            t = 0;
            for (int b = R - 1; b >= 0; b--) begin
                trial = t | (1 << b);
                dac_p = R'(trial);
                dac_n = R'((1 << R) - trial);
                #1;
                expc = (mst && (mu + int'(offset) >= trial)) ? 1 : 0;
                chk("comp_p", int'(comp_p), expc);
                chk("comp_n", int'(comp_n), mst ? 1 - expc : 0);
                if (comp_p) t = trial;
                @(negedge clk);
            end
            comps = t;
            resq.push_back(t);
            res = (bad_last && k == n - 1) ? ((t + 1) & ((1 << R) - 1)) : t;
            rdy = 1'b1;
            result = R'(res);
            sample = (k < n - 1);
            @(negedge clk);
            if (mst) begin
                m_conv++;
                if (res != clampv(mu + int'(offset))) begin
                    m_err++;
                    m_mis = 1'b1;
                end
            end
            if (k < n - 1) model_rise();
            else mst = 1'b0;
            rdy = 1'b0;
            sample = 1'b0;
            #1;
            chk("conv_cnt", int'(conv_cnt), m_conv);
            chk("err_cnt", int'(err_cnt), m_err);
            chk("mismatch", int'(mismatch), int'(m_mis));
            chk("underflow", int'(underflow), int'(m_unf));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[6];
        int comps;
        vif.vin_valid_i = 1'b0;
        vif.vin_i = '0;
        tbl[0] = '{200, 1'b0, 200, 8'hC8};
        tbl[1] = '{0,   1'b0, 0,   8'h00};
        tbl[2] = '{127, 1'b0, 127, 8'h7F};
        tbl[3] = '{128, 1'b0, 128, 8'h80};
        tbl[4] = '{255, 1'b0, 255, 8'hFF};
        tbl[5] = '{16,  1'b1, 16,  8'h10};

        model_clear();
        @(negedge clk);
        @(negedge clk);
        #1 check_reset_state();
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            push(tbl[i].code);
            conv_seq(1, tbl[i].bad, comps);
            chk("tbl_expected", int'(expected), tbl[i].exp_res);
            chk("tbl_comps", comps, tbl[i].exp_comps);
        end
        chk("tbl_conv_cnt", int'(conv_cnt), 6);
        chk("tbl_err_cnt", int'(err_cnt), 1);
        chk("tbl_mismatch", int'(mismatch), 1);

        // Back-to-back pair
        push(5);
        push(250);
        conv_seq(2, 1'b0, comps);
        chk("b2b_conv_cnt", int'(conv_cnt), 8);
        chk("b2b_err_cnt", int'(err_cnt), 1);

        // Underflow on empty FIFO
        sample = 1'b1;
        @(negedge clk);
        model_rise();
        sample = 1'b0;
        dac_p = 8'd1;
        dac_n = 8'd255;
        #1;
        chk("unf_flag", int'(underflow), 1);
        chk("unf_comp_p", int'(comp_p), 0);
        chk("unf_comp_n", int'(comp_n), 0);
        chk("unf_conv_cnt", int'(conv_cnt), m_conv);
        @(negedge clk);

        // Fill FIFO, refused push, drain
        for (int i = 0; i < D; i++) push(i * 30 + 1);
        push(9);
        conv_seq(D, 1'b0, comps);
        push(77);
        conv_seq(1, 1'b0, comps);
        chk("after_full", comps, 77);

        // Reset mid-conversion
        push(64);
        push(3);
        sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        dac_p = 8'd128;
        dac_n = 8'd128;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1 check_reset_state();
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        sample = 1'b1;
        @(negedge clk);
        model_rise();
        sample = 1'b0;
        #1 chk("post_rst_unf", int'(underflow), 1);
        @(negedge clk);

        // Randomised traffic against the model
        for (int it = 0; it < 30; it++) begin
            int np;
            np = $urandom_range(1, 3);
            for (int j = 0; j < np; j++) push($urandom_range(0, 255));
            conv_seq(mq.size(), ($urandom_range(0, 7) == 0), comps);
        end

`ifdef SAR_AFE_OFFSET_EN
        offset = -8'sd3;
        resq.delete();
        push(1);
        push(100);
        conv_seq(2, 1'b0, comps);
        chk("off_res0", resq[0], 0);
        chk("off_res1", resq[1], 97);
        offset = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
